// File: rtl/ascon_cmd_responder.sv
// ascon_cmd_responder: opcode decoder, data/text/result FIFOs and start/done
// sequencing for the ASCON permutation core.
`default_nettype none

module ascon_cmd_responder #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instruction,
  input  logic             cmd_valid,
  input  logic [WIDTH-1:0] data_block,
  input  logic             data_blk_en,
  input  logic [WIDTH-1:0] txt_block,
  input  logic             txt_blk_en,
  output logic [10:0]      status_reg,
  output logic [WIDTH-1:0] ascon_out,
  output logic [5:0]       core_op,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  output logic [WIDTH-1:0] core_txt,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  localparam logic [5:0] OP_KEY_LD             = 6'h01;
  localparam logic [5:0] OP_NONCE_LD           = 6'h02;
  localparam logic [5:0] OP_INIT               = 6'h03;
  localparam logic [5:0] OP_DATA_FIFO_PUSH     = 6'h04;
  localparam logic [5:0] OP_TXT_FIFO_PUSH      = 6'h05;
  localparam logic [5:0] OP_ENC_DATA           = 6'h06;
  localparam logic [5:0] OP_ENC_DATA_LAST      = 6'h07;
  localparam logic [5:0] OP_ENC_TEXT           = 6'h08;
  localparam logic [5:0] OP_ENC_TEXT_LAST      = 6'h09;
  localparam logic [5:0] OP_TAG_CALC_ENC       = 6'h0a;
  localparam logic [5:0] OP_TEXT_OUT_FIFO_PULL = 6'h0b;
  localparam logic [5:0] OP_RESET              = 6'h3f;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_EXEC      = 2'd1,
    S_WAIT_CORE = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t           state_q;
  logic [5:0]       core_op_q;
  logic             core_start_q;
  logic [WIDTH-1:0] data_hold_q, txt_hold_q, ascon_out_q;
  logic             err_illegal_q, err_overflow_q, err_underflow_q;

  logic [WIDTH-1:0] dmem_q [DEPTH];
  logic [WIDTH-1:0] tmem_q [DEPTH];
  logic [WIDTH-1:0] omem_q [DEPTH];
  logic [AW:0]      dwr_q, drd_q, twr_q, trd_q, owr_q, ord_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic d_empty, d_full, t_empty, t_full, o_empty, o_full;
  assign d_empty = (dwr_q == drd_q);
  assign d_full  = (dwr_q[AW] != drd_q[AW]) && (dwr_q[AW-1:0] == drd_q[AW-1:0]);
  assign t_empty = (twr_q == trd_q);
  assign t_full  = (twr_q[AW] != trd_q[AW]) && (twr_q[AW-1:0] == trd_q[AW-1:0]);
  assign o_empty = (owr_q == ord_q);
  assign o_full  = (owr_q[AW] != ord_q[AW]) && (owr_q[AW-1:0] == ord_q[AW-1:0]);

  logic is_enc_data, is_enc_text;
  assign is_enc_data = (core_op_q == OP_ENC_DATA) || (core_op_q == OP_ENC_DATA_LAST);
  assign is_enc_text = (core_op_q == OP_ENC_TEXT) || (core_op_q == OP_ENC_TEXT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      core_op_q       <= 6'd0;
      core_start_q    <= 1'b0;
      data_hold_q     <= '0;
      txt_hold_q      <= '0;
      ascon_out_q     <= '0;
      err_illegal_q   <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      dwr_q <= '0; drd_q <= '0;
      twr_q <= '0; trd_q <= '0;
      owr_q <= '0; ord_q <= '0;
    end else begin
      core_start_q <= 1'b0;
      if (data_blk_en) data_hold_q <= data_block;
      if (txt_blk_en)  txt_hold_q  <= txt_block;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            core_op_q <= instruction;
            state_q   <= S_EXEC;
          end
        end

        S_EXEC: begin
          state_q <= S_DONE;
          case (core_op_q)
            OP_DATA_FIFO_PUSH: begin
              if (d_full) err_overflow_q <= 1'b1;
              else begin
                dmem_q[dwr_q[AW-1:0]] <= data_hold_q;
                dwr_q <= dwr_q + PTR_ONE;
              end
            end
            OP_TXT_FIFO_PUSH: begin
              if (t_full) err_overflow_q <= 1'b1;
              else begin
                tmem_q[twr_q[AW-1:0]] <= txt_hold_q;
                twr_q <= twr_q + PTR_ONE;
              end
            end
            OP_TEXT_OUT_FIFO_PULL: begin
              if (o_empty) err_underflow_q <= 1'b1;
              else begin
                ascon_out_q <= omem_q[ord_q[AW-1:0]];
                ord_q <= ord_q + PTR_ONE;
              end
            end
            OP_KEY_LD, OP_NONCE_LD, OP_INIT, OP_TAG_CALC_ENC: begin
              core_start_q <= 1'b1;
              state_q      <= S_WAIT_CORE;
            end
            OP_ENC_DATA, OP_ENC_DATA_LAST: begin
              if (d_empty) err_underflow_q <= 1'b1;
              else begin
                core_start_q <= 1'b1;
                state_q      <= S_WAIT_CORE;
              end
            end
            OP_ENC_TEXT, OP_ENC_TEXT_LAST: begin
              if (t_empty) err_underflow_q <= 1'b1;
              if (o_full)  err_overflow_q  <= 1'b1;
              if (!t_empty && !o_full) begin
                core_start_q <= 1'b1;
                state_q      <= S_WAIT_CORE;
              end
            end
            OP_RESET: begin
              dwr_q <= '0; drd_q <= '0;
              twr_q <= '0; trd_q <= '0;
              owr_q <= '0; ord_q <= '0;
              err_illegal_q   <= 1'b0;
              err_overflow_q  <= 1'b0;
              err_underflow_q <= 1'b0;
              ascon_out_q     <= '0;
            end
            default: err_illegal_q <= 1'b1;
          endcase
        end

        S_WAIT_CORE: begin
          if (core_done) begin
            if (is_enc_data) drd_q <= drd_q + PTR_ONE;
            if (is_enc_text) begin
              trd_q <= trd_q + PTR_ONE;
              omem_q[owr_q[AW-1:0]] <= core_result;
              owr_q <= owr_q + PTR_ONE;
            end
            state_q <= S_DONE;
          end
        end

        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign status_reg = {err_underflow_q, err_overflow_q, err_illegal_q,
                       o_full, o_empty, t_full, t_empty, d_full, d_empty,
                       (state_q != S_IDLE), (state_q == S_IDLE)};
  assign ascon_out  = ascon_out_q;
  assign core_op    = core_op_q;
  assign core_start = core_start_q;
  assign core_data  = dmem_q[drd_q[AW-1:0]];
  assign core_txt   = tmem_q[trd_q[AW-1:0]];

endmodule

`default_nettype wire

// File: tb/tb_ascon_cmd_responder.sv
// Directed bench for ascon_cmd_responder with FIFO scoreboards and a core model.
`default_nettype none

module tb_ascon_cmd_responder;

  localparam logic [5:0] OP_DATA_FIFO_PUSH     = 6'h04;
  localparam logic [5:0] OP_TXT_FIFO_PUSH      = 6'h05;
  localparam logic [5:0] OP_ENC_DATA           = 6'h06;
  localparam logic [5:0] OP_ENC_TEXT           = 6'h08;
  localparam logic [5:0] OP_TEXT_OUT_FIFO_PULL = 6'h0b;
  localparam logic [5:0] OP_RESET              = 6'h3f;
  localparam logic [5:0] OP_UNDEFINED          = 6'h2a;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   instruction;
  logic         cmd_valid;
  logic [127:0] data_block;
  logic         data_blk_en;
  logic [127:0] txt_block;
  logic         txt_blk_en;
  logic [10:0]  status_reg;
  logic [127:0] ascon_out;
  logic [5:0]   core_op;
  logic         core_start;
  logic [127:0] core_data;
  logic [127:0] core_txt;
  logic         core_done;
  logic [127:0] core_result;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int cyc;

  logic [127:0] dq[$];
  logic [127:0] tq[$];
  logic [127:0] oq[$];

  ascon_cmd_responder dut (
    .clk(clk), .rst(rst), .instruction(instruction), .cmd_valid(cmd_valid),
    .data_block(data_block), .data_blk_en(data_blk_en),
    .txt_block(txt_block), .txt_blk_en(txt_blk_en),
    .status_reg(status_reg), .ascon_out(ascon_out), .core_op(core_op),
    .core_start(core_start), .core_data(core_data), .core_txt(core_txt),
    .core_done(core_done), .core_result(core_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; block enables, if requested, ride on the same cycle.
  task automatic send(input logic [5:0] op, input logic den, input logic ten);
    instruction = op;
    cmd_valid   = 1'b1;
    data_blk_en = den;
    txt_blk_en  = ten;
    tick();
    cmd_valid   = 1'b0;
    data_blk_en = 1'b0;
    txt_blk_en  = 1'b0;
  endtask

  task automatic wait_next(output int n);
    n = 0;
    while (status_reg[0] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL next_timeout: observed next=%b expected 1", status_reg[0]);
    end
  endtask

  initial begin
    rst = 1'b1; instruction = 6'd0; cmd_valid = 1'b0;
    data_block = '0; data_blk_en = 1'b0; txt_block = '0; txt_blk_en = 1'b0;
    core_done = 1'b0; core_result = '0;

    // 1. Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_status", {117'd0, status_reg}, 128'h055);
    check("reset_ascon_out", ascon_out, 128'h0);
    check("reset_no_start", start_cnt, 0);

    // 2. Data push
    data_block = 128'h00112233445566778899aabbccddeeff;
    dq.push_back(data_block);
    send(OP_DATA_FIFO_PUSH, 1'b1, 1'b0);
    check("push_next_low0", status_reg[0], 1'b0);
    tick();
    check("push_next_low1", status_reg[0], 1'b0);
    tick();
    check("push_next_high", status_reg[0], 1'b1);
    check("push_dfifo_not_empty", status_reg[2], 1'b0);
    check("push_core_data", core_data, dq[0]);

    // 3. Text FIFO overflow
    for (int i = 0; i < 5; i++) begin
      txt_block = {4{32'hC0DE0000 + 32'(i)}};
      if (tq.size() < 4) tq.push_back(txt_block);
      send(OP_TXT_FIFO_PUSH, 1'b0, 1'b1);
      wait_next(cyc);
      if (i == 0) check("txt_push_latency", cyc, 2);
      if (i == 3) begin
        check("tfifo_full_after4", status_reg[5], 1'b1);
        check("no_overflow_after4", status_reg[9], 1'b0);
      end
    end
    check("overflow_after5", status_reg[9], 1'b1);
    check("tfifo_head_unchanged", core_txt, tq[0]);

    send(OP_RESET, 1'b0, 1'b0);
    wait_next(cyc);
    check("reset_op_status", {117'd0, status_reg}, 128'h055);
    dq.delete(); tq.delete(); oq.delete();

    // 4. Encrypt one text block through the core model
    txt_block = {16{8'hA5}};
    tq.push_back(txt_block);
    send(OP_TXT_FIFO_PUSH, 1'b0, 1'b1);
    wait_next(cyc);
    check("enc_core_txt", core_txt, tq[0]);
    start_cnt = 0;
    send(OP_ENC_TEXT, 1'b0, 1'b0);
    tick();
    check("enc_start_pulse", core_start, 1'b1);
    repeat (6) tick();
    core_result = {16{8'h5A}};
    core_done = 1'b1;
    void'(tq.pop_front());
    oq.push_back(core_result);
    tick();
    core_done = 1'b0;
    wait_next(cyc);
    check("enc_done_latency", cyc, 1);
    check("enc_one_start", start_cnt, 1);
    check("enc_tfifo_empty", status_reg[4], 1'b1);
    check("enc_ofifo_not_empty", status_reg[6], 1'b0);
    check("enc_ofifo_not_full", status_reg[7], 1'b0);
    send(OP_TEXT_OUT_FIFO_PULL, 1'b0, 1'b0);
    wait_next(cyc);
    check("pull_ascon_out", ascon_out, oq.pop_front());
    check("pull_ofifo_empty", status_reg[6], 1'b1);

    // 5. Underflow, illegal opcode, RESET opcode
    start_cnt = 0;
    send(OP_ENC_DATA, 1'b0, 1'b0);
    wait_next(cyc);
    check("underflow_no_start", start_cnt, 0);
    check("underflow_bit", status_reg[10], 1'b1);
    send(OP_UNDEFINED, 1'b0, 1'b0);
    wait_next(cyc);
    check("illegal_bit", status_reg[8], 1'b1);
    check("illegal_latency", cyc, 2);
    send(OP_RESET, 1'b0, 1'b0);
    wait_next(cyc);
    check("reset_op_status2", {117'd0, status_reg}, 128'h055);
    check("reset_op_ascon_out", ascon_out, 128'h0);

    // 6. Abort while waiting on the core
    txt_block = {8{16'hBEEF}};
    send(OP_TXT_FIFO_PUSH, 1'b0, 1'b1);
    wait_next(cyc);
    send(OP_ENC_TEXT, 1'b0, 1'b0);
    tick();
    check("abort_busy", status_reg[1], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_result = {8{16'hDEAD}};
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    check("abort_status", {117'd0, status_reg}, 128'h055);
    check("abort_core_op", {122'd0, core_op}, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ascon_cmd_responder.md
Name: ascon_cmd_responder

Overview:
Command-side responder for the ASCON system. It accepts 6-bit opcodes (Opcodes.v macros) plus data/text block pushes from a host or program sequencer. It buffers associated data, plaintext and results in three FIFOs, sequences the permutation core through a start/done handshake, and reports progress through an 11-bit status word whose bit 0 ("next") tells the host when it may issue the next instruction.

Parameters:
WIDTH, 128, block width of data, text and result paths
DEPTH, 4, entries per FIFO (power of two)
AW, 2, FIFO pointer width, equal to log2(DEPTH)

Ports:
clk  in  1  clock; all logic updates on the rising edge
rst  in  1  synchronous, active-high reset
instruction  in  6  opcode, sampled when cmd_valid=1 and status_reg[0]=1
cmd_valid  in  1  host strobe, one cycle per instruction
data_block  in  WIDTH  associated-data block
data_blk_en  in  1  loads data_block into the data holding register
txt_block  in  WIDTH  plaintext block
txt_blk_en  in  1  loads txt_block into the text holding register
status_reg  out  11  [0] next, [1] busy, [2] dfifo_empty, [3] dfifo_full, [4] tfifo_empty, [5] tfifo_full, [6] ofifo_empty, [7] ofifo_full, [8] err_illegal, [9] err_overflow, [10] err_underflow
ascon_out  out  WIDTH  last block pulled from the output FIFO
core_op  out  6  latched opcode presented to the core
core_start  out  1  one-cycle start pulse to the core
core_data  out  WIDTH  data FIFO head
core_txt  out  WIDTH  text FIFO head
core_done  in  1  core completion pulse
core_result  in  WIDTH  core output, valid when core_done=1

Behaviour:
- FSM states: IDLE, EXEC, WAIT_CORE, DONE. next=1 only in IDLE; busy = not IDLE.
- Reset (rst=1 at an edge):
  - state goes to IDLE; all FIFOs flushed; holding registers, ascon_out and core_op cleared to 0; core_start=0; error bits cleared.
  - From the following cycle status_reg = 11'h055.
  - Reset mid-operation aborts the command, and any pending core_done is ignored.
- Holding registers load on any cycle with their _blk_en=1, in every state.
- Command acceptance:
  - IDLE + cmd_valid: opcode latched into core_op, go to EXEC; next=0 from the next cycle.
  - cmd_valid outside IDLE is ignored.
- EXEC (one cycle) actions by opcode:
  - DATA_FIFO_PUSH / TXT_FIFO_PUSH: write the holding register into the FIFO, then go to DONE. FIFO full: no write, set err_overflow.
  - TEXT_OUT_FIFO_PULL: pop the output FIFO into ascon_out, then DONE. FIFO empty: ascon_out unchanged, set err_underflow.
  - KEY_LD, NONCE_LD, INIT, TAG_CALC_ENC: pulse core_start, go to WAIT_CORE.
  - ENC_DATA(_LAST): requires dfifo non-empty. Otherwise set err_underflow, no start, go to DONE.
  - ENC_TEXT(_LAST): requires tfifo non-empty and ofifo not full. Otherwise set err_underflow / err_overflow respectively, no start, go to DONE.
  - RESET (6'h3f): flush FIFOs, clear errors and ascon_out, then DONE.
  - Any other opcode: set err_illegal, then DONE.
- WAIT_CORE: wait indefinitely for core_done. On core_done:
  - ENC_DATA*: pop dfifo.
  - ENC_TEXT*: pop tfifo and push core_result into ofifo.
  - Then go to DONE.
  - core_done in any other state is ignored.
- DONE goes to IDLE after one cycle.
- Latency from the accept edge to next=1: push/pull/RESET/error commands 2 cycles; core commands 3 cycles + core latency (edges from core_done to next=1: 2).
- FIFOs are circular with AW-bit pointers plus wrap bit. Full = pointers equal with wrap differing; empty = all equal. Pointers wrap from DEPTH-1 to 0.
- A push and pop never coincide on the same FIFO.
- Error bits are sticky until rst or the RESET opcode.

Test Plan:
1. Reset: rst high 2 cycles, then low -> status_reg=11'h055, ascon_out=0, core_start never asserted.
2. Data push: data_blk_en with data_block=128'h0011…ff plus cmd_valid, DATA_FIFO_PUSH -> next low 2 cycles, then 1; status_reg[2]=0; core_data=128'h0011…ff.
3. Overflow: 5 TXT_FIFO_PUSH commands -> after 4th, status_reg[5]=1; after 5th, status_reg[9]=1 and FIFO contents unchanged.
4. Encrypt text: push text 128'hA5…, ENC_TEXT; core returns core_done with core_result=128'h5A… after 7 cycles -> exactly one core_start, tfifo empty, ofifo holds 1 entry. Then TEXT_OUT_FIFO_PULL -> ascon_out=128'h5A….
5. Underflow/illegal: ENC_DATA with dfifo empty -> no core_start, status_reg[10]=1. Opcode with no Opcodes.v definition -> status_reg[8]=1. RESET 6'h3f -> status_reg=11'h055.
6. Abort: rst asserted while in WAIT_CORE, then core_done pulsed -> IDLE, FIFOs empty, no ofifo write.
